pi_dac_output_stage: RTL and testbench

Consumer end of the PI controller output interface. It takes the signed Q1.15 controller output with its valid strobe and clamps it to programmable min/max limits. It returns the `limiting` flag that drives the controller's `pi_limiting` anti-windup input, converts the result to an offset-binary DAC code, and serialises it as an SPI-style frame to an external 16-bit DAC. It sits between `pi_controller` and the DAC pins.

---
 rtl/pi_output_pkg.sv | 28 ++
 rtl/spi_frame_shifter.sv | 129 ++++++++++++
 rtl/pi_dac_output_stage.sv | 105 ++++++++++
 tb/tb_pi_dac_output_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_output_pkg.sv
// Shared definitions for the PI controller output stage: frame FSM states,
// frame length derivation and signed-to-offset-binary conversion helpers.
package pi_output_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } frame_state_t;

    localparam int MAX_WIDTH = 32;

    function automatic int frame_bits_f(input int cmd_bits, input int data_width);
        return cmd_bits + data_width;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] midscale_f(input int data_width);
        return MAX_WIDTH'(1) << (data_width - 1);
    endfunction

    // Offset binary is two's complement with the sign bit flipped.
    function automatic logic [MAX_WIDTH-1:0] offset_binary_f(input logic [MAX_WIDTH-1:0] value,
                                                             input int data_width);
        return value ^ midscale_f(data_width);
    endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Serialises one frame MSB first on an SPI-style link: sync_n framing,
// sclk idling low, sdi updated on sclk rise, minimum sync_n high gap.
module spi_frame_shifter
    import pi_output_pkg::*;
#(
    parameter int FRAME_BITS       = 24,
    parameter int SCLK_DIV         = 4,
    parameter int SYNC_HIGH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic [FRAME_BITS-1:0] frame_data,
    output logic                  load_ack,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  sclk,
    output logic                  sync_n,
    output logic                  sdi
);

    localparam int HALF_W = $clog2(2 * SCLK_DIV + 1);
    localparam int BIT_W  = $clog2(FRAME_BITS + 1);
    localparam int GAP_W  = $clog2(SYNC_HIGH_CYCLES + 1);

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * SCLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_FALL = HALF_W'(SCLK_DIV);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SYNC_HIGH_CYCLES - 1);

    frame_state_t          state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [HALF_W-1:0]     half_q, half_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  sclk_q, sclk_d;
    logic                  sync_n_q, sync_n_d;
    logic                  sdi_q, sdi_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            half_q   <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            sclk_q   <= 1'b0;
            sync_n_q <= 1'b1;
            sdi_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            sclk_q   <= sclk_d;
            sync_n_q <= sync_n_d;
            sdi_q    <= sdi_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        half_d   = half_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        sclk_d   = sclk_q;
        sync_n_d = sync_n_q;
        sdi_d    = sdi_q;
        done_d   = 1'b0;
        load_ack = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_req) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                load_ack = 1'b1;
                shreg_d  = frame_data;
                sync_n_d = 1'b0;
                sdi_d    = frame_data[FRAME_BITS-1];
                sclk_d   = 1'b0;
                half_d   = '0;
                bit_d    = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Rising sclk presents the current bit; the DAC samples on the fall.
                if (half_q == '0) begin
                    sclk_d = 1'b1;
                    sdi_d  = shreg_q[FRAME_BITS-1];
                end
                if (half_q == HALF_FALL) sclk_d = 1'b0;
                if (half_q == HALF_LAST) begin
                    half_d  = '0;
                    shreg_d = shreg_q << 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        done_d   = 1'b1;
                        sync_n_d = 1'b1;
                        sdi_d    = 1'b0;
                        gap_d    = '0;
                        state_d  = ST_GAP;
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = load_req ? ST_LOAD : ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;
    assign sclk       = sclk_q;
    assign sync_n     = sync_n_q;
    assign sdi        = sdi_q;

endmodule

// File: rtl/pi_dac_output_stage.sv
// PI controller output stage: clamps each sample, reports limiting for
// anti-windup, and forwards the newest offset-binary code to the DAC shifter.
module pi_dac_output_stage
    import pi_output_pkg::*;
#(
    parameter int                  DATA_WIDTH       = 16,
    parameter int                  CMD_BITS         = 8,
    parameter logic [CMD_BITS-1:0] DAC_CMD          = 8'h30,
    parameter int                  SCLK_DIV         = 4,
    parameter int                  SYNC_HIGH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] limit_max,
    input  logic [DATA_WIDTH-1:0] limit_min,
    output logic                  limiting,
    output logic [DATA_WIDTH-1:0] dac_code,
    output logic                  dac_sclk,
    output logic                  dac_sync_n,
    output logic                  dac_sdi,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           dropped_count
);

    localparam int FRAME_BITS = frame_bits_f(CMD_BITS, DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MIDSCALE = DATA_WIDTH'(midscale_f(DATA_WIDTH));

    logic                  limiting_q, limiting_d;
    logic [DATA_WIDTH-1:0] code_q, code_d;
    logic [DATA_WIDTH-1:0] pend_code_q, pend_code_d;
    logic                  pend_full_q, pend_full_d;
    logic [15:0]           drop_q, drop_d;
    logic [DATA_WIDTH-1:0] clamp_hi;
    logic [DATA_WIDTH-1:0] clamped;
    logic [DATA_WIDTH-1:0] offset_code;
    logic                  load_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            limiting_q  <= 1'b0;
            code_q      <= MIDSCALE;
            pend_code_q <= MIDSCALE;
            pend_full_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            limiting_q  <= limiting_d;
            code_q      <= code_d;
            pend_code_q <= pend_code_d;
            pend_full_q <= pend_full_d;
            drop_q      <= drop_d;
        end
    end

    // Applying the lower clamp last makes limit_min win when the limits cross.
    always_comb begin
        clamp_hi    = ($signed(data_in) > $signed(limit_max)) ? limit_max : data_in;
        clamped     = ($signed(clamp_hi) < $signed(limit_min)) ? limit_min : clamp_hi;
        offset_code = DATA_WIDTH'(offset_binary_f(MAX_WIDTH'(clamped), DATA_WIDTH));

        limiting_d  = limiting_q;
        code_d      = code_q;
        pend_code_d = pend_code_q;
        pend_full_d = pend_full_q;
        drop_d      = drop_q;

        if (load_ack) pend_full_d = 1'b0;
        if (!enable) begin
            pend_full_d = 1'b0;
            limiting_d  = 1'b0;
        end else if (data_valid) begin
            limiting_d  = (clamped != data_in);
            code_d      = offset_code;
            pend_code_d = offset_code;
            pend_full_d = 1'b1;
            if (pend_full_q && !load_ack && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
    end

    // Gating with enable stops a disabled stage from starting a new frame.
    spi_frame_shifter #(
        .FRAME_BITS       (FRAME_BITS),
        .SCLK_DIV         (SCLK_DIV),
        .SYNC_HIGH_CYCLES (SYNC_HIGH_CYCLES)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load_req   (pend_full_q & enable),
        .frame_data ({DAC_CMD, pend_code_q}),
        .load_ack   (load_ack),
        .busy       (busy),
        .frame_done (frame_done),
        .sclk       (dac_sclk),
        .sync_n     (dac_sync_n),
        .sdi        (dac_sdi)
    );

    assign limiting      = limiting_q;
    assign dac_code      = code_q;
    assign dropped_count = drop_q;

endmodule

// File: tb/tb_pi_dac_output_stage.sv
// Randomised bench for pi_dac_output_stage against a cycle-timed behavioural
// model of clamping, latest-wins buffering and frame timing.
module tb_pi_dac_output_stage;

    localparam int FB     = 24;
    localparam int PERIOD = 99;
    localparam logic [7:0] CMD = 8'h30;

    logic        clk = 1'b0;
    logic        reset, enable, data_valid;
    logic [15:0] data_in, limit_max, limit_min;
    logic        limiting, dac_sclk, dac_sync_n, dac_sdi, busy, frame_done;
    logic [15:0] dac_code, dropped_count;

    pi_dac_output_stage #(
        .DATA_WIDTH       (16),
        .CMD_BITS         (8),
        .DAC_CMD          (8'h30),
        .SCLK_DIV         (2),
        .SYNC_HIGH_CYCLES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .limit_max     (limit_max),
        .limit_min     (limit_min),
        .limiting      (limiting),
        .dac_code      (dac_code),
        .dac_sclk      (dac_sclk),
        .dac_sync_n    (dac_sync_n),
        .dac_sdi       (dac_sdi),
        .busy          (busy),
        .frame_done    (frame_done),
        .dropped_count (dropped_count)
    );

    always #5 clk = ~clk;

    int          total_checks = 0;
    int          bad_checks = 0;
    int          edge_num = 0;
    bit          pend_valid = 0;
    int          pend_at = 0;
    logic [15:0] pend_code = 16'h8000;
    int          last_load = -1000;
    logic [23:0] last_frame = '0;
    logic        exp_limiting = 1'b0;
    logic [15:0] exp_code = 16'h8000;
    int          exp_drop = 0;
    logic [23:0] exp_frames[$];
    bit          abort_ok = 1;
    logic [15:0] cur_hi = 16'h7FFF;
    logic [15:0] cur_lo = 16'h8000;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_checks++;
        if (got !== want) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, want, edge_num);
        end
    endtask

    function automatic int clamp_ref(input int x, input int hi, input int lo);
        int v;
        v = x;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    task automatic updateModel(input logic rst, input logic en, input logic valid,
                               input logic [15:0] din, input logic [15:0] hi, input logic [15:0] lo);
        int v;
        edge_num++;
        if (rst) begin
            pend_valid   = 0;
            last_load    = -1000;
            exp_limiting = 1'b0;
            exp_code     = 16'h8000;
            exp_drop     = 0;
            return;
        end
        if (pend_valid && pend_at == edge_num) begin
            last_frame = {CMD, pend_code};
            exp_frames.push_back(last_frame);
            last_load  = edge_num;
            pend_valid = 0;
        end
        if (!en) begin
            pend_valid   = 0;
            exp_limiting = 1'b0;
        end else if (valid) begin
            v = clamp_ref(int'($signed(din)), int'($signed(hi)), int'($signed(lo)));
            exp_limiting = (v != int'($signed(din)));
            exp_code     = 16'(v + 32768);
            if (pend_valid) begin
                if (exp_drop < 65535) exp_drop++;
            end else begin
                pend_valid = 1;
                pend_at    = (edge_num + 2 > last_load + PERIOD) ? edge_num + 2 : last_load + PERIOD;
            end
            pend_code = exp_code;
        end
    endtask

    task automatic checkPins();
        int  e;
        int  idx;
        bit  in_frame;
        bit  exp_sclk, exp_sdi, exp_busy, exp_done;
        e        = edge_num;
        in_frame = (e >= last_load) && (e <= last_load + 4 * FB - 1);
        exp_sclk = (e >= last_load + 1) && (e <= last_load + 4 * FB) && (((e - last_load - 1) % 4) < 2);
        exp_sdi  = 1'b0;
        if (in_frame) begin
            idx     = (e == last_load) ? 0 : (e - last_load - 1) / 4;
            exp_sdi = last_frame[FB - 1 - idx];
        end
        exp_busy = (pend_valid && e >= pend_at - 1) || (e >= last_load - 1 && e <= last_load + 97);
        exp_done = (e == last_load + 4 * FB);
        checkOutput("limiting", 32'(limiting), 32'(exp_limiting));
        checkOutput("dac_code", 32'(dac_code), 32'(exp_code));
        checkOutput("dropped", 32'(dropped_count), 32'(exp_drop));
        checkOutput("sync_n", 32'(dac_sync_n), 32'(!in_frame));
        checkOutput("sclk", 32'(dac_sclk), 32'(exp_sclk));
        checkOutput("sdi", 32'(dac_sdi), 32'(exp_sdi));
        checkOutput("busy", 32'(busy), 32'(exp_busy));
        checkOutput("frame_done", 32'(frame_done), 32'(exp_done));
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic valid,
                                 input logic [15:0] din, input logic [15:0] hi, input logic [15:0] lo);
        reset      = rst;
        enable     = en;
        data_valid = valid;
        data_in    = din;
        limit_max  = hi;
        limit_min  = lo;
        @(posedge clk);
        updateModel(rst, en, valid, din, hi, lo);
        #1;
        checkPins();
    endtask

    task automatic idleCycles(input int n, input logic en);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, en, 1'b0, 16'h0000, cur_hi, cur_lo);
    endtask

    // Receiver side: shift sdi in on each falling sclk while sync_n is low.
    logic [23:0] rx_word = '0;
    int          rx_bits = 0;

    always @(negedge dac_sync_n) rx_bits <= 0;

    always @(negedge dac_sclk) begin
        if (!dac_sync_n) begin
            rx_word <= {rx_word[22:0], dac_sdi};
            rx_bits <= rx_bits + 1;
        end
    end

    always @(posedge dac_sync_n) begin
        if (rx_bits == FB) begin
            checkOutput("frame_queued", 32'(exp_frames.size() > 0), 32'd1);
            if (exp_frames.size() > 0) checkOutput("frame_word", 32'(rx_word), 32'(exp_frames.pop_front()));
        end else if (abort_ok) begin
            if (exp_frames.size() > 0) void'(exp_frames.pop_front());
        end else begin
            checkOutput("frame_bits", 32'(rx_bits), 32'(FB));
        end
    end

    initial begin
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, cur_hi, cur_lo);
        abort_ok = 0;
        checkOutput("rst_code", 32'(dac_code), 32'h8000);
        checkOutput("rst_sync", 32'(dac_sync_n), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        idleCycles(3, 1'b1);

        // Zero sample: sync_n falls two edges after acceptance.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, cur_hi, cur_lo);
        checkOutput("zero_code", 32'(dac_code), 32'h8000);
        checkOutput("zero_lim", 32'(limiting), 32'd0);
        idleCycles(1, 1'b1);
        checkOutput("zero_sync_t1", 32'(dac_sync_n), 32'd1);
        idleCycles(1, 1'b1);
        checkOutput("zero_sync_t2", 32'(dac_sync_n), 32'd0);
        idleCycles(110, 1'b1);

        cur_hi = 16'h4000;
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h7000, cur_hi, cur_lo);
        checkOutput("clamp_code", 32'(dac_code), 32'hC000);
        checkOutput("clamp_lim", 32'(limiting), 32'd1);
        idleCycles(110, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h1000, cur_hi, cur_lo);
        checkOutput("pass_code", 32'(dac_code), 32'h9000);
        checkOutput("pass_lim", 32'(limiting), 32'd0);
        idleCycles(110, 1'b1);

        // Latest-wins: the middle sample is overwritten.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0100, cur_hi, cur_lo);
        idleCycles(9, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0200, cur_hi, cur_lo);
        idleCycles(9, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0300, cur_hi, cur_lo);
        idleCycles(200, 1'b1);
        checkOutput("latest_drop", 32'(dropped_count), 32'd1);

        cur_hi = 16'h0800;
        cur_lo = 16'h1000;
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0C00, cur_hi, cur_lo);
        checkOutput("cross_code", 32'(dac_code), 32'h9000);
        checkOutput("cross_lim", 32'(limiting), 32'd1);
        idleCycles(110, 1'b1);

        // Reset at the start of bit 10 of a frame.
        cur_hi = 16'h7FFF;
        cur_lo = 16'h8000;
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234, cur_hi, cur_lo);
        idleCycles(43, 1'b1);
        abort_ok = 1;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, cur_hi, cur_lo);
        checkOutput("abort_sync", 32'(dac_sync_n), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_drop", 32'(dropped_count), 32'd0);
        abort_ok = 0;
        idleCycles(5, 1'b1);

        // Enable falls during bit 5 with a newer sample pending.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0400, cur_hi, cur_lo);
        idleCycles(10, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0500, cur_hi, cur_lo);
        idleCycles(12, 1'b1);
        idleCycles(150, 1'b0);
        checkOutput("disable_lim", 32'(limiting), 32'd0);
        checkOutput("disable_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                cur_hi = 16'($urandom);
                cur_lo = 16'($urandom);
            end
            applyStimulus(1'b0, $urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0,
                          16'($urandom), cur_hi, cur_lo);
        end
        idleCycles(250, 1'b1);
        checkOutput("frames_drained", 32'(exp_frames.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
